// File: rtl/regfile_pkg.sv
// Shared constants and types for the register-file port A arbiter.
// Optional build macro: REGFILE_CLEAR_EN (zero-fill the register file after reset).
package regfile_pkg;

    localparam int unsigned ADDR_W   = 6;
    localparam int unsigned DATA_W   = 16;
    localparam int unsigned NUM_REGS = 2 ** ADDR_W;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    // One requester's access bundle as presented to port A.
    typedef struct packed {
        logic              req;
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } req_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter; on a conflict the requester that was not granted last wins.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    logic last_q;

    // Combinational grant; at most one bit set.
    always_comb begin
        gnt = 2'b00;
        if (en) begin
            if (req[0] && (!req[1] || last_q)) begin
                gnt[0] = 1'b1;
            end else if (req[1]) begin
                gnt[1] = 1'b1;
            end
        end
    end

    // Remember the most recently granted index; reset favours requester 0 first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= 1'b1;
        end else if (|gnt) begin
            last_q <= gnt[1];
        end
    end

endmodule

// File: rtl/regfile_arbiter.sv
// Shares register-file port A between game logic (0) and host/debug (1).
// Build macro REGFILE_CLEAR_EN adds a 64-cycle zero-fill phase after reset.
module regfile_arbiter
    import regfile_pkg::*;
(
    input  logic              Clock,
    input  logic              nReset,
    input  logic              Req0,
    input  logic              Write0,
    input  logic [ADDR_W-1:0] Addr0,
    input  logic [DATA_W-1:0] WData0,
    output logic              Gnt0,
    output logic              RValid0,
    output logic [DATA_W-1:0] RData0,
    input  logic              Req1,
    input  logic              Write1,
    input  logic [ADDR_W-1:0] Addr1,
    input  logic [DATA_W-1:0] WData1,
    output logic              Gnt1,
    output logic              RValid1,
    output logic [DATA_W-1:0] RData1,
    output logic              Ready,
    output logic [ADDR_W-1:0] RfAddressA,
    output logic [DATA_W-1:0] RfWriteData,
    output logic              RfWriteEnable,
    input  logic [DATA_W-1:0] RfReadDataA
);

    req_t              rq0;
    req_t              rq1;
    logic [1:0]        gnt;
    logic              ready_q;
    logic              rvalid0_q;
    logic              rvalid1_q;
    logic [DATA_W-1:0] rdata0_q;
    logic [DATA_W-1:0] rdata1_q;
    state_t            state_q;
    logic              clearing;
    logic [ADDR_W-1:0] clr_addr;

    assign rq0 = '{req: Req0, write: Write0, addr: Addr0, wdata: WData0};
    assign rq1 = '{req: Req1, write: Write1, addr: Addr1, wdata: WData1};

    rr_arbiter2 u_arb (
        .clk   (Clock),
        .rst_n (nReset),
        .en    (ready_q),
        .req   ({rq1.req, rq0.req}),
        .gnt   (gnt)
    );

`ifdef REGFILE_CLEAR_EN
    state_t            state_d;
    logic [ADDR_W-1:0] clr_cnt_q;

    // State register.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state_q <= CLEAR;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: leave CLEAR after the last address has been written.
    always_comb begin
        state_d = state_q;
        if ((state_q == CLEAR) && (clr_cnt_q == ADDR_W'(NUM_REGS - 1))) begin
            state_d = RUN;
        end
    end

    // Clear address counter; wraps to 0 as CLEAR ends.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            clr_cnt_q <= '0;
        end else if (state_q == CLEAR) begin
            clr_cnt_q <= clr_cnt_q + ADDR_W'(1);
        end
    end

    assign clearing = (state_q == CLEAR);
    assign clr_addr = clr_cnt_q;
`else
    assign state_q  = RUN;
    assign clearing = 1'b0;
    assign clr_addr = '0;
`endif

    // Port A drive: zero-fill while clearing (idle while in reset), otherwise the granted access.
    always_comb begin
        RfAddressA    = '0;
        RfWriteData   = '0;
        RfWriteEnable = 1'b0;
        if (clearing) begin
            if (nReset) begin
                RfAddressA    = clr_addr;
                RfWriteEnable = 1'b1;
            end
        end else if (gnt[0]) begin
            RfAddressA    = rq0.addr;
            RfWriteData   = rq0.wdata;
            RfWriteEnable = rq0.write;
        end else if (gnt[1]) begin
            RfAddressA    = rq1.addr;
            RfWriteData   = rq1.wdata;
            RfWriteEnable = rq1.write;
        end
    end

    // Ready follows the RUN state one cycle late so no grant overlaps the last clear write.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            ready_q <= 1'b0;
        end else begin
            ready_q <= (state_q == RUN);
        end
    end

    // Capture read data for the granted reader; RData holds until that requester reads again.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
        end else begin
            rvalid0_q <= gnt[0] & ~rq0.write;
            rvalid1_q <= gnt[1] & ~rq1.write;
            if (gnt[0] && !rq0.write) begin
                rdata0_q <= RfReadDataA;
            end
            if (gnt[1] && !rq1.write) begin
                rdata1_q <= RfReadDataA;
            end
        end
    end

    assign Gnt0    = gnt[0];
    assign Gnt1    = gnt[1];
    assign Ready   = ready_q;
    assign RValid0 = rvalid0_q;
    assign RValid1 = rvalid1_q;
    assign RData0  = rdata0_q;
    assign RData1  = rdata1_q;

endmodule

// File: tb/tb_regfile_arbiter.sv
// Bench for regfile_arbiter: register-file model, grant/port-A model and read-data scoreboard.
`timescale 1ns/1ps
module tb_regfile_arbiter;
    import regfile_pkg::*;

`ifdef REGFILE_CLEAR_EN
    localparam bit CLEAR_EN = 1'b1;
    localparam int READY_AT = 65;
`else
    localparam bit CLEAR_EN = 1'b0;
    localparam int READY_AT = 1;
`endif

    logic              Clock = 1'b0;
    logic              nReset = 1'b0;
    logic              Req0 = 1'b0, Write0 = 1'b0, Req1 = 1'b0, Write1 = 1'b0;
    logic [ADDR_W-1:0] Addr0 = '0, Addr1 = '0;
    logic [DATA_W-1:0] WData0 = '0, WData1 = '0;
    logic              Gnt0, Gnt1, RValid0, RValid1, Ready, RfWriteEnable;
    logic [DATA_W-1:0] RData0, RData1, RfWriteData, RfReadDataA;
    logic [ADDR_W-1:0] RfAddressA;

    int checks = 0;
    int failures = 0;

    regfile_arbiter dut (
        .Clock(Clock), .nReset(nReset),
        .Req0(Req0), .Write0(Write0), .Addr0(Addr0), .WData0(WData0),
        .Gnt0(Gnt0), .RValid0(RValid0), .RData0(RData0),
        .Req1(Req1), .Write1(Write1), .Addr1(Addr1), .WData1(WData1),
        .Gnt1(Gnt1), .RValid1(RValid1), .RData1(RData1),
        .Ready(Ready), .RfAddressA(RfAddressA), .RfWriteData(RfWriteData),
        .RfWriteEnable(RfWriteEnable), .RfReadDataA(RfReadDataA)
    );

    always #5 Clock = ~Clock;

    // Register file model: combinational read, write on the rising edge.
    logic [DATA_W-1:0] mem [NUM_REGS];
    assign RfReadDataA = mem[RfAddressA];
    always @(posedge Clock) if (RfWriteEnable) mem[RfAddressA] <= RfWriteData;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
        checks++;
        if (got !== expv) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, expv, $time);
        end
    endtask

    // Expected-state model.
    int                cyc = 0;
    logic              tb_last = 1'b1;
    logic              erv0 = 1'b0, erv1 = 1'b0;
    logic [DATA_W-1:0] erd0 = '0, erd1 = '0;
    logic [DATA_W-1:0] q0[$];
    logic [DATA_W-1:0] q1[$];
    logic [DATA_W-1:0] shadow [NUM_REGS];

    always @(negedge Clock) begin : mon
        logic rdy, clr, g0, g1, ew;
        logic [ADDR_W-1:0] ea;
        logic [DATA_W-1:0] ed;
        if (!nReset) begin
            cyc = 0; tb_last = 1'b1; erv0 = 1'b0; erv1 = 1'b0; erd0 = '0; erd1 = '0;
            q0.delete(); q1.delete();
            check("rst_ready", Ready, 0);
            check("rst_gnt", {Gnt1, Gnt0}, 0);
            check("rst_rvalid", {RValid1, RValid0}, 0);
            check("rst_rdata", {RData1, RData0}, 0);
            check("rst_rf", {RfWriteEnable, RfAddressA, RfWriteData}, 0);
        end else begin
            rdy = (cyc >= READY_AT);
            clr = CLEAR_EN && (cyc < NUM_REGS);
            check("ready", Ready, rdy);
            check("rvalid0", RValid0, erv0);
            if (erv0) begin
                if (q0.size() > 0) erd0 = q0.pop_front();
                else check("sb0_underflow", 1, 0);
            end
            check("rdata0", RData0, erd0);
            check("rvalid1", RValid1, erv1);
            if (erv1) begin
                if (q1.size() > 0) erd1 = q1.pop_front();
                else check("sb1_underflow", 1, 0);
            end
            check("rdata1", RData1, erd1);
            g0 = rdy && Req0 && (!Req1 || tb_last);
            g1 = rdy && Req1 && !g0;
            check("gnt0", Gnt0, g0);
            check("gnt1", Gnt1, g1);
            check("gnt_excl", Gnt0 & Gnt1, 0);
            ea = '0; ed = '0; ew = 1'b0;
            if (clr) begin
                ea = ADDR_W'(cyc); ew = 1'b1; shadow[ea] = '0;
            end else if (g0) begin
                ea = Addr0; ed = WData0; ew = Write0;
            end else if (g1) begin
                ea = Addr1; ed = WData1; ew = Write1;
            end
            check("rf_we", RfWriteEnable, ew);
            check("rf_addr", RfAddressA, ea);
            check("rf_wdata", RfWriteData, ed);
            erv0 = g0 && !Write0;
            erv1 = g1 && !Write1;
            if (erv0) q0.push_back(shadow[Addr0]);
            if (erv1) q1.push_back(shadow[Addr1]);
            if (g0 && Write0) shadow[Addr0] = WData0;
            if (g1 && Write1) shadow[Addr1] = WData1;
            if (g0 || g1) tb_last = g1;
            cyc++;
        end
    end

    // Hold a request until granted, then drop it just after the grant edge.
    task automatic access0(input logic wr, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        bit got = 1'b0;
        Req0 = 1'b1; Write0 = wr; Addr0 = a; WData0 = d;
        for (int n = 0; n < 150; n++) begin
            @(negedge Clock);
            if (Gnt0) begin got = 1'b1; break; end
        end
        @(posedge Clock); #1;
        Req0 = 1'b0; Write0 = 1'b0;
        if (!got) check("gnt0_timeout", 0, 1);
    endtask

    task automatic access1(input logic wr, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        bit got = 1'b0;
        Req1 = 1'b1; Write1 = wr; Addr1 = a; WData1 = d;
        for (int n = 0; n < 150; n++) begin
            @(negedge Clock);
            if (Gnt1) begin got = 1'b1; break; end
        end
        @(posedge Clock); #1;
        Req1 = 1'b0; Write1 = 1'b0;
        if (!got) check("gnt1_timeout", 0, 1);
    endtask

    initial begin
        for (int i = 0; i < NUM_REGS; i++) begin
            mem[i]    = 16'(32'hA500 + i);
            shadow[i] = 16'(32'hA500 + i);
        end
        repeat (3) @(posedge Clock);
        #1 nReset = 1'b1;

        // Post-reset reads (zero after clear when enabled).
        access0(1'b0, 6'd0, '0);
        access0(1'b0, 6'd31, '0);
        access0(1'b0, 6'd63, '0);

        // Single write then read-after-write.
        access0(1'b1, 6'd5, 16'hBEEF);
        access0(1'b0, 6'd5, '0);

        // Sustained conflict: grants alternate.
        fork
            begin access0(1'b1, 6'd10, 16'h1111); access0(1'b1, 6'd10, 16'h1111); end
            begin access1(1'b1, 6'd11, 16'h2222); access1(1'b1, 6'd11, 16'h2222); end
        join
        access0(1'b0, 6'd10, '0);
        access1(1'b0, 6'd11, '0);

        // Same-address race, requester 0 favoured (reads old value).
        access1(1'b0, 6'd20, '0);
        fork
            access0(1'b0, 6'd3, '0);
            access1(1'b1, 6'd3, 16'h00AA);
        join
        // Same-address race, requester 1 favoured (read sees new value).
        access0(1'b0, 6'd40, '0);
        fork
            access0(1'b0, 6'd3, '0);
            access1(1'b1, 6'd3, 16'h0055);
        join

        // Back-to-back single-requester traffic.
        for (int i = 0; i < 8; i++) access0(1'b1, 6'(32 + i), 16'(i * 32'h111));
        for (int i = 0; i < 8; i++) access0(1'b0, 6'(32 + i), '0);

        // Reset with a read result in flight.
        access0(1'b0, 6'd5, '0);
        nReset = 1'b0;
        #1;
        check("async_rvalid_cancel", RValid0, 0);
        check("async_ready", Ready, 0);
        repeat (2) @(posedge Clock);
        #1 nReset = 1'b1;

`ifdef REGFILE_CLEAR_EN
        // Reset in the middle of the clear sweep.
        repeat (20) @(posedge Clock);
        #2 nReset = 1'b0;
        #1;
        check("async_clr_we", RfWriteEnable, 0);
        check("async_clr_addr", RfAddressA, 0);
        repeat (2) @(posedge Clock);
        #1 nReset = 1'b1;
`endif

        access0(1'b0, 6'd5, '0);
        access1(1'b0, 6'd3, '0);
        repeat (4) @(posedge Clock);
        @(negedge Clock);
        check("sb_drain", 32'(q0.size() + q1.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
